// File: rtl/lsu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_arb_pkg
// Description : Shared types and constants for the two-master LSU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_arb_pkg;

  // Which master was granted the shared LSU port in the previous cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // Width of the M1 starvation counter; must hold the largest legal limit (15)
  localparam int LSU_ARB_STARVE_W = 4;

  // Default number of consecutive denials tolerated before M1 is forced through
  localparam int LSU_ARB_STARVE_LIMIT_DEF = 4;

endpackage : lsu_arb_pkg
`default_nettype wire

// File: rtl/lsu_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : lsu_arb_starve_cnt
// Description : Counts consecutive cycles M1 requests without being granted,
//               saturating at STARVE_LIMIT; flags when the limit is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_arb_starve_cnt
  import lsu_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = LSU_ARB_STARVE_LIMIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_at_limit
);

  localparam logic [LSU_ARB_STARVE_W-1:0] C_LIMIT = LSU_ARB_STARVE_W'(STARVE_LIMIT);

  logic [LSU_ARB_STARVE_W-1:0] r_cnt;
  logic                        w_at_limit;

  assign w_at_limit = (r_cnt == C_LIMIT);
  assign o_at_limit = w_at_limit;

  // Count denied requests, hold at the limit, clear on grant or idle request
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_req && !i_gnt) begin
      if (!w_at_limit) begin
        r_cnt <= r_cnt + {{(LSU_ARB_STARVE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= '0;
    end
  end

endmodule : lsu_arb_starve_cnt
`default_nettype wire

// File: rtl/lsu_arb.sv
`default_nettype none
// ============================================================================
// Module      : lsu_arb
// Description : Two-master arbiter for a shared load/store unit port. M0 (core)
//               has priority; M1 (secondary/debug) is protected from starvation
//               and may lock the port for one extra cycle (read-modify-write).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_arb
  import lsu_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = LSU_ARB_STARVE_LIMIT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // master 0 (core)
  input  logic        i_m0_req,
  input  logic        i_m0_wren,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [2:0]  i_m0_func3,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  // master 1 (secondary/debug)
  input  logic        i_m1_req,
  input  logic        i_m1_wren,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [2:0]  i_m1_func3,
  input  logic        i_m1_lock,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  // shared LSU port
  output logic        o_lsu_wren,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic [2:0]  o_func3,
  input  logic [31:0] i_ld_data
);

  owner_e      r_owner;
  owner_e      w_owner_nxt;
  logic        r_lock;
  logic        w_lock_nxt;
  logic        w_lock_act;
  logic        w_m0_gnt;
  logic        w_m1_gnt;
  logic        w_starve_at_limit;

  logic        r_m0_rvalid;
  logic [31:0] r_m0_rdata;
  logic        r_m1_rvalid;
  logic [31:0] r_m1_rdata;

  lsu_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_m1_req),
    .i_gnt      (w_m1_gnt),
    .o_at_limit (w_starve_at_limit)
  );

  // Owner/lock state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_owner <= OWN_NONE;
      r_lock  <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  // Grant decision and next owner/lock; a lock never re-arms from its own locked cycle
  always_comb begin
    w_owner_nxt = OWN_NONE;
    w_lock_nxt  = 1'b0;
    w_m0_gnt    = 1'b0;
    w_m1_gnt    = 1'b0;
    w_lock_act  = r_lock && (r_owner == OWN_M1);
    if (i_rst_n) begin
      if (i_m1_req && (w_lock_act || !i_m0_req || w_starve_at_limit)) begin
        w_m1_gnt = 1'b1;
      end else if (i_m0_req) begin
        w_m0_gnt = 1'b1;
      end
      if (w_m1_gnt) begin
        w_owner_nxt = OWN_M1;
      end else if (w_m0_gnt) begin
        w_owner_nxt = OWN_M0;
      end
      w_lock_nxt = w_m1_gnt && i_m1_lock && !w_lock_act;
    end
  end

  // Route the granted master's attributes onto the LSU; idle port drives zeros
  always_comb begin
    o_lsu_wren = 1'b0;
    o_lsu_addr = '0;
    o_st_data  = '0;
    o_func3    = '0;
    if (w_m0_gnt) begin
      o_lsu_wren = i_m0_wren;
      o_lsu_addr = i_m0_addr;
      o_st_data  = i_m0_wdata;
      o_func3    = i_m0_func3;
    end else if (w_m1_gnt) begin
      o_lsu_wren = i_m1_wren;
      o_lsu_addr = i_m1_addr;
      o_st_data  = i_m1_wdata;
      o_func3    = i_m1_func3;
    end
  end

  // Capture load data for the master whose read was granted; rdata holds between pulses
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_m0_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rvalid <= 1'b0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_m0_gnt && !i_m0_wren;
      r_m1_rvalid <= w_m1_gnt && !i_m1_wren;
      if (w_m0_gnt && !i_m0_wren) begin
        r_m0_rdata <= i_ld_data;
      end
      if (w_m1_gnt && !i_m1_wren) begin
        r_m1_rdata <= i_ld_data;
      end
    end
  end

  assign o_m0_gnt    = w_m0_gnt;
  assign o_m1_gnt    = w_m1_gnt;
  assign o_m0_rvalid = r_m0_rvalid;
  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_rvalid = r_m1_rvalid;
  assign o_m1_rdata  = r_m1_rdata;

endmodule : lsu_arb
`default_nettype wire
